// File: rtl/seq_divider32.sv
// seq_divider32: multi-cycle 32-bit restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN to add the Signed port and the sign-fixup (FIX) state.
module seq_divider32 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
`ifdef SIGNED_DIV_EN
    input  logic        Signed,
`endif
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
`ifdef SIGNED_DIV_EN
        FIX,
`endif
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] r_q, r_d, q_q, q_d, d_q, d_d;
    logic [31:0] quot_q, quot_d, rem_q, rem_d;
    logic        dz_q, dz_d;
    logic        sgn_in;
    logic [31:0] a_mag, b_mag, shift, r_nxt, q_nxt;
    logic [32:0] trial;

`ifdef SIGNED_DIV_EN
    logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
    assign sgn_in = Signed;
    assign Busy   = (state_q == CALC) || (state_q == FIX);
`else
    assign sgn_in = 1'b0;
    assign Busy   = (state_q == CALC);
`endif

    assign a_mag     = (sgn_in && Dividend[31]) ? -Dividend : Dividend;
    assign b_mag     = (sgn_in && Divisor[31]) ? -Divisor : Divisor;
    assign Done      = (state_q == DONE);
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivZero   = dz_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef SIGNED_DIV_EN
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef SIGNED_DIV_EN
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        // q_q holds the dividend bits still to be consumed, shifting in quotient bits from the right
        shift   = {r_q[30:0], q_q[31]};
        trial   = {1'b0, shift} - {1'b0, d_q};
        r_nxt   = trial[32] ? shift : trial[31:0];
        q_nxt   = {q_q[30:0], ~trial[32]};
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start && Divisor == '0) begin
                    state_d = DONE;
                    quot_d  = '1;
                    rem_d   = Dividend;
                    dz_d    = 1'b1;
                end else if (Start) begin
                    state_d = CALC;
                    dz_d    = 1'b0;
                    r_d     = '0;
                    q_d     = a_mag;
                    d_d     = b_mag;
                    cnt_d   = '0;
`ifdef SIGNED_DIV_EN
                    sgn_d   = sgn_in;
                    qneg_d  = sgn_in && (Dividend[31] ^ Divisor[31]);
                    rneg_d  = sgn_in && Dividend[31];
`endif
                end
            end
            CALC: begin
                r_d   = r_nxt;
                q_d   = q_nxt;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    quot_d  = q_nxt;
                    rem_d   = r_nxt;
`ifdef SIGNED_DIV_EN
                    if (sgn_q) state_d = FIX;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            FIX: begin
                state_d = DONE;
                quot_d  = qneg_q ? -q_q : q_q;
                rem_d   = rneg_q ? -r_q : r_q;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: table-driven vectors plus hand-written handshake, abort and back-to-back sequences.
module tb_seq_divider32;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [31:0] Dividend = '0;
    logic [31:0] Divisor = '0;
    logic [31:0] Quotient, Remainder;
    logic        Busy, Done, DivZero;
`ifdef SIGNED_DIV_EN
    logic        sg = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    seq_divider32 dut (
        .CLK(CLK),
        .RST(RST),
        .Start(Start),
        .Dividend(Dividend),
        .Divisor(Divisor),
`ifdef SIGNED_DIV_EN
        .Signed(sg),
`endif
        .Quotient(Quotient),
        .Remainder(Remainder),
        .Busy(Busy),
        .Done(Done),
        .DivZero(DivZero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go(input logic [31:0] a, input logic [31:0] b, input bit s);
        @(negedge CLK);
        Dividend = a;
        Divisor  = b;
`ifdef SIGNED_DIV_EN
        sg = s;
`else
        if (s) $display("note: Signed request ignored in unsigned build");
`endif
        Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
    endtask

    // Entered #1 after the accepting edge; lat counts edges after it until Done is seen.
    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!Done && lat < 200) begin
            if (Busy) busy_n++;
            @(posedge CLK);
            #1 lat++;
        end
    endtask

    initial begin
        int lat, busy_n;
        vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,    1'b0, 32});
        vecs.push_back('{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,    1'b0, 32});
        vecs.push_back('{32'd5,          32'hFFFFFFFF,   1'b0, 32'd0,          32'd5,    1'b0, 32});
        vecs.push_back('{32'd1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'd1234, 1'b1, 0});
        vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,    1'b0, 32});
        vecs.push_back('{32'd7,          32'd7,          1'b0, 32'd1,          32'd0,    1'b0, 32});
        vecs.push_back('{32'd6,          32'd7,          1'b0, 32'd0,          32'd6,    1'b0, 32});
        vecs.push_back('{32'h80000000,   32'd2,          1'b0, 32'h40000000,   32'd0,    1'b0, 32});
        vecs.push_back('{32'hFFFFFFFF,   32'h00010000,   1'b0, 32'h0000FFFF,   32'h0000FFFF, 1'b0, 32});
        vecs.push_back('{32'd1000000,    32'd1000,       1'b0, 32'd1000,       32'd0,    1'b0, 32});
`ifdef SIGNED_DIV_EN
        vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF, 1'b0, 33});
        vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,    1'b0, 33});
        vecs.push_back('{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,    1'b0, 33});
        vecs.push_back('{32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5,    1'b1, 0});
        vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,    1'b0, 32});
`endif

        @(posedge CLK);
        #1;
        chk("reset_q", Quotient, 32'd0);
        chk("reset_r", Remainder, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_done", {31'd0, Done}, 32'd0);
        chk("reset_dz", {31'd0, DivZero}, 32'd0);
        @(negedge CLK) RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            go(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done(lat, busy_n);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), busy_n, vecs[i].dz ? 0 : vecs[i].lat);
            chk($sformatf("v%0d_busy_at_done", i), {31'd0, Busy}, 32'd0);
            chk($sformatf("v%0d_q", i), Quotient, vecs[i].q);
            chk($sformatf("v%0d_r", i), Remainder, vecs[i].r);
            chk($sformatf("v%0d_dz", i), {31'd0, DivZero}, {31'd0, vecs[i].dz});
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {31'd0, Done}, 32'd0);
            chk($sformatf("v%0d_q_hold", i), Quotient, vecs[i].q);
        end

        // Back-to-back: second Start raised during the Done cycle of the first.
        go(32'hFFFFFFFF, 32'd1, 1'b0);
        wait_done(lat, busy_n);
        chk("b2b_first_q", Quotient, 32'hFFFFFFFF);
        chk("b2b_first_r", Remainder, 32'd0);
        Dividend = 32'd5;
        Divisor  = 32'hFFFFFFFF;
        Start    = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        chk("b2b_no_gap_busy", {31'd0, Busy}, 32'd1);
        chk("b2b_no_gap_done", {31'd0, Done}, 32'd0);
        wait_done(lat, busy_n);
        chk("b2b_second_latency", lat, 32);
        chk("b2b_second_q", Quotient, 32'd0);
        chk("b2b_second_r", Remainder, 32'd5);

        // Divide-by-zero followed by a valid Start that must clear DivZero.
        go(32'd1234, 32'd0, 1'b0);
        chk("dz_done", {31'd0, Done}, 32'd1);
        chk("dz_flag", {31'd0, DivZero}, 32'd1);
        chk("dz_busy", {31'd0, Busy}, 32'd0);
        @(posedge CLK);
        #1 chk("dz_flag_held", {31'd0, DivZero}, 32'd1);
        go(32'd50, 32'd5, 1'b0);
        chk("dz_cleared", {31'd0, DivZero}, 32'd0);
        wait_done(lat, busy_n);
        chk("dz_next_q", Quotient, 32'd10);

        // Start during CALC must be ignored.
        go(32'd100, 32'd7, 1'b0);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        Dividend = 32'd9;
        Divisor  = 32'd3;
        Start    = 1'b1;
        @(negedge CLK) Start = 1'b0;
        wait_done(lat, busy_n);
        chk("ignore_latency", lat + 11, 32);
        chk("ignore_q", Quotient, 32'd14);
        chk("ignore_r", Remainder, 32'd2);

        // Asynchronous reset mid-CALC aborts with no Done.
        go(32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("abort_q", Quotient, 32'd0);
        chk("abort_r", Remainder, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(posedge CLK);
                #1 if (Done) seen++;
                if (c == 2) RST = 1'b0;
            end
            chk("abort_no_done", seen, 0);
        end
        go(32'd50, 32'd5, 1'b0);
        wait_done(lat, busy_n);
        chk("after_abort_latency", lat, 32);
        chk("after_abort_q", Quotient, 32'd10);
        chk("after_abort_r", Remainder, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
